// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch state encoding and program counter width
package fetch_unit_pkg;

  // Program counter width shared with the instruction ROM and branch LUT
  localparam int PC_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, fetch sequencer and retired-instruction counter
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W       = PC_W_DEFAULT,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BranchEn,
  input  logic             ConditionBranch,
  input  logic             CondFlag,
  input  logic [PC_W-1:0]  Target,
  input  logic             Halt,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_count;

  logic             w_taken;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_count_inc;
  logic [PC_W-1:0]  w_pc_next;

  // Branch resolves in the same cycle: decoder inputs come straight from ROM[ProgCtr]
  assign w_taken     = BranchEn & (~ConditionBranch | CondFlag);
  // Counter sticks at all-ones rather than wrapping
  assign w_cnt_sat   = &r_count;
  assign w_count_inc = w_cnt_sat ? r_count : r_count + 1'b1;
  // Target is absolute; sequential fetch wraps naturally at 2^PC_W
  assign w_pc_next   = w_taken ? Target : r_pc + 1'b1;

  // Sequencer: state, PC and retire counter advance together; Start is ignored in RUN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_pc    <= START_PC;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (Start) begin
            r_state <= RUN;
            r_pc    <= START_PC;
            r_count <= '0;
          end
        end
        RUN: begin
          r_count <= w_count_inc;
          if (Halt) begin
            r_state <= HALTED;
          end else begin
            r_pc <= w_pc_next;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pc    <= START_PC;
          r_count <= '0;
        end
      endcase
    end
  end

  assign ProgCtr    = r_pc;
  assign InstrCount = r_count;
  assign Running    = (r_state == RUN);
  assign Done       = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural model
module tb_fetch_unit;

  logic       Clk;
  logic       Reset;
  // main instance (PC_W=10, CNT_W=16)
  logic       Start, BranchEn, ConditionBranch, CondFlag, Halt;
  logic [9:0] Target;
  logic [9:0] ProgCtr;
  logic       Running, Done;
  logic [15:0] InstrCount;
  // small instance (PC_W=4, CNT_W=3) for wrap and saturation
  logic       s_Start, s_BranchEn, s_ConditionBranch, s_CondFlag, s_Halt;
  logic [3:0] s_Target;
  logic [3:0] s_ProgCtr;
  logic       s_Running, s_Done;
  logic [2:0] s_InstrCount;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  fetch_unit #(.PC_W(10), .START_ADDR(0), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchEn(BranchEn),
    .ConditionBranch(ConditionBranch), .CondFlag(CondFlag), .Target(Target),
    .Halt(Halt), .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
    .InstrCount(InstrCount)
  );

  fetch_unit #(.PC_W(4), .START_ADDR(0), .CNT_W(3)) dut_small (
    .Clk(Clk), .Reset(Reset), .Start(s_Start), .BranchEn(s_BranchEn),
    .ConditionBranch(s_ConditionBranch), .CondFlag(s_CondFlag), .Target(s_Target),
    .Halt(s_Halt), .ProgCtr(s_ProgCtr), .Running(s_Running), .Done(s_Done),
    .InstrCount(s_InstrCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: running/done flags, integer PC and counter
  int m_pc = 0, m_cnt = 0;
  bit m_run = 0, m_done = 0;
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_pc = 0; m_cnt = 0; m_run = 0; m_done = 0;
    end else if (m_run) begin
      if (Halt) begin
        m_run = 0; m_done = 1;
      end else if (BranchEn && (!ConditionBranch || CondFlag)) begin
        m_pc = int'(Target);
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
      if (m_cnt < 65535) m_cnt++;
    end else if (Start) begin
      m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0;
    end
  end

  int s_pc = 0, s_cnt = 0;
  bit s_run = 0, s_done = 0;
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s_pc = 0; s_cnt = 0; s_run = 0; s_done = 0;
    end else if (s_run) begin
      if (s_Halt) begin
        s_run = 0; s_done = 1;
      end else if (s_BranchEn && (!s_ConditionBranch || s_CondFlag)) begin
        s_pc = int'(s_Target);
      end else begin
        s_pc = (s_pc + 1) % 16;
      end
      if (s_cnt < 7) s_cnt++;
    end else if (s_Start) begin
      s_run = 1; s_done = 0; s_pc = 0; s_cnt = 0;
    end
  end

  // Every cycle, away from the rising edge, compare both instances to the model
  always @(negedge Clk) begin
    if (cmp_en) begin
      check("cyc_pc",      int'(ProgCtr),      m_pc);
      check("cyc_cnt",     int'(InstrCount),   m_cnt);
      check("cyc_running", int'(Running),      int'(m_run));
      check("cyc_done",    int'(Done),         int'(m_done));
      check("cyc_s_pc",    int'(s_ProgCtr),    s_pc);
      check("cyc_s_cnt",   int'(s_InstrCount), s_cnt);
      check("cyc_s_run",   int'(s_Running),    int'(s_run));
      check("cyc_s_done",  int'(s_Done),       int'(s_done));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic set_br(input logic en, input logic cond, input logic flag, input int tgt);
    BranchEn = en; ConditionBranch = cond; CondFlag = flag; Target = 10'(tgt);
  endtask

  initial begin
    Reset = 1'b0;
    Start = 0; BranchEn = 0; ConditionBranch = 0; CondFlag = 0; Halt = 0; Target = '0;
    s_Start = 0; s_BranchEn = 0; s_ConditionBranch = 0; s_CondFlag = 0; s_Halt = 0; s_Target = '0;

    tick(2);
    check("rst_pc",      int'(ProgCtr), 0);
    check("rst_cnt",     int'(InstrCount), 0);
    check("rst_running", int'(Running), 0);
    check("rst_done",    int'(Done), 0);
    Reset = 1'b1;
    cmp_en = 1;
    tick();
    check("idle_hold_pc", int'(ProgCtr), 0);

    // Start pulse, then straight-line fetch
    Start = 1; tick(); Start = 0;
    check("start_running", int'(Running), 1);
    check("start_pc",      int'(ProgCtr), 0);
    tick(3);
    check("seq_pc3",  int'(ProgCtr), 3);
    check("seq_cnt3", int'(InstrCount), 3);
    tick(2);
    check("seq_pc5", int'(ProgCtr), 5);

    // Unconditional branch, CondFlag=1 then CondFlag=0
    set_br(1, 0, 1, 40); tick();
    check("uncond_f1", int'(ProgCtr), 40);
    set_br(1, 0, 0, 5); tick();
    set_br(1, 0, 0, 40); tick();
    check("uncond_f0", int'(ProgCtr), 40);

    // Conditional branch not taken, then taken
    set_br(1, 0, 0, 7); tick();
    set_br(1, 1, 0, 2); tick();
    check("cond_not_taken", int'(ProgCtr), 8);
    set_br(1, 0, 0, 7); tick();
    set_br(1, 1, 1, 2); tick();
    check("cond_taken", int'(ProgCtr), 2);

    // Halt wins over branch at PC 12
    set_br(1, 0, 0, 12); tick();
    check("pre_halt_pc", int'(ProgCtr), 12);
    set_br(1, 0, 0, 0); Halt = 1; tick();
    check("halt_done", int'(Done), 1);
    check("halt_pc",   int'(ProgCtr), 12);
    check("halt_cnt",  int'(InstrCount), 14);
    tick(10);
    check("halt_hold_pc",   int'(ProgCtr), 12);
    check("halt_hold_cnt",  int'(InstrCount), 14);
    check("halt_hold_done", int'(Done), 1);
    Start = 1; tick(); Start = 0; Halt = 0; set_br(0, 0, 0, 0);
    check("restart_pc",   int'(ProgCtr), 0);
    check("restart_cnt",  int'(InstrCount), 0);
    check("restart_done", int'(Done), 0);

    // Start held across a halt: one HALTED cycle then restart; Start ignored in RUN
    tick(2);
    Halt = 1; Start = 1; tick();
    check("held_halt_done", int'(Done), 1);
    check("held_halt_pc",   int'(ProgCtr), 2);
    Halt = 0; tick();
    check("held_restart_run", int'(Running), 1);
    check("held_restart_pc",  int'(ProgCtr), 0);
    tick();
    check("start_in_run_pc", int'(ProgCtr), 1);
    Start = 0;
    tick(8);
    check("pre_reset_pc", int'(ProgCtr), 9);

    // Asynchronous reset between edges
    #1 Reset = 1'b0;
    #1;
    check("async_pc",      int'(ProgCtr), 0);
    check("async_running", int'(Running), 0);
    check("async_cnt",     int'(InstrCount), 0);
    tick();
    Reset = 1'b1;
    tick();

    // Small instance: PC wrap at 4 bits, counter saturation at 3 bits
    s_Start = 1; tick(); s_Start = 0;
    s_BranchEn = 1; s_Target = 4'd14; tick(); s_BranchEn = 0;
    check("wrap_14", int'(s_ProgCtr), 14);
    tick();
    check("wrap_15", int'(s_ProgCtr), 15);
    tick();
    check("wrap_0", int'(s_ProgCtr), 0);
    tick();
    check("wrap_1", int'(s_ProgCtr), 1);
    tick(6);
    check("sat_cnt", int'(s_InstrCount), 7);
    check("sat_pc",  int'(s_ProgCtr), 7);

    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program counter and fetch sequencer for the 9-bit basic processor; sits directly upstream of the control decoder.
- Drives ProgCtr into the asynchronous-read instruction ROM, whose 9-bit output feeds the control decoder.
- Consumes the decoder's BranchEn, ConditionBranch and Halt outputs, plus the ALU compare flag and the branch-target LUT output.
- Owns the start/done handshake with the testbench and keeps a retired-instruction counter.

Parameters:
- PC_W, 10, program counter width in bits (ROM depth 2^PC_W).
- START_ADDR, 0, PC value loaded at reset and on each Start.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  level/pulse from bench; sampled on Clk.
- BranchEn  input  1  from decoder: current instruction is a branch.
- ConditionBranch  input  1  from decoder: 1 means conditional, 0 means unconditional.
- CondFlag  input  1  registered ALU compare flag.
- Target  input  PC_W  absolute branch target from LUT.
- Halt  input  1  from decoder: current instruction is halt.
- ProgCtr  output  PC_W  address to instruction ROM.
- Running  output  1  high in RUN state.
- Done  output  1  high in HALTED state.
- InstrCount  output  CNT_W  instructions retired since last Start.

Behaviour:
- States:
  - IDLE: ProgCtr held, no retire.
  - RUN: one instruction retires per cycle.
  - HALTED: ProgCtr frozen at the halt address, Done=1.
- Reset asserted (Reset=0), asynchronously: state=IDLE, ProgCtr=START_ADDR, InstrCount=0, Running=0, Done=0. Outputs take these values immediately, not at the next edge.
- IDLE, Start=1 at edge -> RUN; ProgCtr=START_ADDR, InstrCount=0. The first instruction executes in the cycle after Start is sampled.
- RUN, each edge (priority top-down):
  - Start=1: ignored while running; no restart.
  - Halt=1: -> HALTED, ProgCtr unchanged, InstrCount+1. Halt wins over BranchEn if both are high.
  - Taken = BranchEn & (~ConditionBranch | CondFlag). If Taken, ProgCtr=Target, else ProgCtr=ProgCtr+1.
  - InstrCount+1 on every RUN edge.
- HALTED, Start=1 at edge -> RUN; ProgCtr=START_ADDR, InstrCount=0. Done falls in the same edge.
- HALTED, Start=0: hold all state, Done=1.
- Start held high across a halt: HALTED lasts exactly one cycle, then restart. The bench must deassert Start to observe Done for more than one cycle.
- PC arithmetic is modulo 2^PC_W; ProgCtr+1 from all-ones wraps to 0 with no flag.
- Target is used verbatim (absolute), never added to ProgCtr.
- InstrCount saturates at 2^CNT_W-1; it does not wrap.
- Running=(state==RUN) and Done=(state==HALTED), both decoded directly from the state register, with no extra latency.
- Decoder inputs are combinational from ROM[ProgCtr] and are valid within the same cycle; there is no fetch latency and no bubble on branches.
- Reset mid-RUN: immediate return to IDLE; the partial InstrCount is discarded.

Decomposition:
- Package definitions gains:
  - typedef enum logic [1:0] fetch_state_t {IDLE, RUN, HALTED}.
  - PC_W default constant, shared with the instruction ROM and branch LUT.
- No sub-module; PC register, state register and counter live in one module.

Test Plan:
- Reset low for 2 cycles, then high; Start=1 one cycle -> Running=1 next cycle, ProgCtr=0, then 1,2,3 with no branches; InstrCount=3 after 3 RUN cycles.
- Unconditional branch: at ProgCtr=5, BranchEn=1, ConditionBranch=0, Target=40 -> next ProgCtr=40. Same setup with CondFlag=0 still gives 40.
- Conditional branch: at ProgCtr=7, BranchEn=1, ConditionBranch=1, Target=2, CondFlag=0 -> ProgCtr=8; repeat with CondFlag=1 -> ProgCtr=2.
- Halt: at ProgCtr=12 with Halt=1 and BranchEn=1, Target=0 -> Done=1, ProgCtr stays 12, InstrCount increments once, then holds for 10 cycles. Start pulse -> ProgCtr=0, InstrCount=0, Done=0.
- Wrap and saturate: PC_W=4, run with no branches from 14 -> 15, 0, 1. CNT_W=3, run 10 cycles -> InstrCount stops at 7.
- Async reset mid-RUN at ProgCtr=9: drop Reset between clock edges -> ProgCtr=0, Running=0 before the next edge; Start=1 during RUN has no effect on ProgCtr.
